// File: rtl/microcode_sequencer.sv
// microcode_sequencer: buffers 9-bit instructions and issues their three fields as zero-extended 4-bit micro-ops.
// Optional SEQ_SKIP_ZERO_EN: zero-valued fields are not issued; an all-zero word retires with no micro-ops.
module microcode_sequencer #(
  parameter int FIFO_DEPTH = 2,
  parameter int LVL_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [8:0]       instr,
  output logic             instr_ready,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [3:0]       uop_data,
  output logic [1:0]       uop_phase,
  output logic             done,
  output logic [LVL_W-1:0] fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, F1, F2, F3} st_t;
  st_t              st_q, st_d, head_st, adv_st;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [LVL_W-1:0] cnt_q;
  logic [8:0]       act_q, act_d, head;
  logic             done_q, done_d, push, pop, xfer;
  // First field at index >= k that must be issued; IDLE means the word retires.
  function automatic st_t first_issue(input logic [8:0] w, input logic [1:0] k);
    if (k <= 2'd1 && (!SKIP || w[8:5] != 4'd0)) return F1;
    if (k <= 2'd2 && (!SKIP || w[4:2] != 3'd0)) return F2;
    if (!SKIP || w[1:0] != 2'd0) return F3;
    return IDLE;
  endfunction
  assign head        = mem_q[rd_q];
  assign instr_ready = cnt_q != LVL_W'(FIFO_DEPTH);
  assign push        = instr_valid && instr_ready;
  assign uop_valid   = st_q != IDLE;
  assign xfer        = uop_valid && uop_ready;
  assign head_st     = first_issue(head, 2'd1);
  assign adv_st      = st_q == F1 ? first_issue(act_q, 2'd2) : st_q == F2 ? first_issue(act_q, 2'd3) : IDLE;
  assign uop_phase   = st_q == F2 ? 2'd1 : st_q == F3 ? 2'd2 : 2'd0;
  assign uop_data    = st_q == F1 ? act_q[8:5] : st_q == F2 ? {1'b0, act_q[4:2]} :
                       st_q == F3 ? {2'b0, act_q[1:0]} : 4'd0;
  assign done        = done_q;
  assign fifo_level  = cnt_q;
  always_comb begin
    st_d   = st_q;
    act_d  = act_q;
    done_d = 1'b0;
    pop    = 1'b0;
    if (st_q == IDLE) begin
      if (cnt_q != '0) begin
        pop    = 1'b1;
        act_d  = head;
        st_d   = head_st;
        done_d = head_st == IDLE;
      end
    end else if (xfer) begin
      st_d = adv_st;
      if (adv_st == IDLE) begin
        done_d = 1'b1;
        // An all-zero head waits for IDLE so its own done pulse stays separate.
        if (cnt_q != '0 && head_st != IDLE) begin
          pop   = 1'b1;
          act_d = head;
          st_d  = head_st;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      act_q  <= '0;
      done_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      act_q  <= act_d;
      done_q <= done_d;
      wr_q   <= wr_q + PW'(push);
      rd_q   <= rd_q + PW'(pop);
      cnt_q  <= cnt_q + LVL_W'(push) - LVL_W'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= instr;
  end
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: queue-based reference model with per-cycle comparison, directed cases, then random traffic.
module tb_microcode_sequencer;
  localparam int DEPTH = 2;
`ifdef SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  logic       clk = 1'b0, reset = 1'b0, instr_valid = 1'b0, uop_ready = 1'b0;
  logic [8:0] instr = '0;
  logic       instr_ready, uop_valid, done;
  logic [3:0] uop_data;
  logic [1:0] uop_phase, fifo_level;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  microcode_sequencer #(.FIFO_DEPTH(DEPTH), .LVL_W(2)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .uop_data(uop_data), .uop_phase(uop_phase), .done(done), .fifo_level(fifo_level)
  );
  typedef struct packed {logic [1:0] ph; logic [3:0] d;} op_t;
  logic [8:0] fq[$];
  op_t        ops[$];
  logic       m_done = 1'b0;
  bit         m_push;
  function automatic void expand(input logic [8:0] w);
    if (!SKIP || w[8:5] != 4'd0) ops.push_back('{ph: 2'd0, d: w[8:5]});
    if (!SKIP || w[4:2] != 3'd0) ops.push_back('{ph: 2'd1, d: {1'b0, w[4:2]}});
    if (!SKIP || w[1:0] != 2'd0) ops.push_back('{ph: 2'd2, d: {2'b0, w[1:0]}});
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fq.delete();
      ops.delete();
      m_done = 1'b0;
    end else begin
      m_push = instr_valid && fq.size() < DEPTH;
      m_done = 1'b0;
      if (ops.size() > 0) begin
        if (uop_ready) begin
          void'(ops.pop_front());
          if (ops.size() == 0) begin
            m_done = 1'b1;
            if (fq.size() > 0 && (!SKIP || fq[0] != 9'd0)) expand(fq.pop_front());
          end
        end
      end else if (fq.size() > 0) begin
        expand(fq.pop_front());
        if (ops.size() == 0) m_done = 1'b1;
      end
      if (m_push) fq.push_back(instr);
    end
  end
  always @(negedge clk) begin
    chk("instr_ready", int'(instr_ready), int'(fq.size() < DEPTH));
    chk("fifo_level", int'(fifo_level), fq.size());
    chk("uop_valid", int'(uop_valid), int'(ops.size() > 0));
    chk("done", int'(done), int'(m_done));
    if (ops.size() > 0) begin
      chk("uop_phase", int'(uop_phase), int'(ops[0].ph));
      chk("uop_data", int'(uop_data), int'(ops[0].d));
    end
  end
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic push(input logic [8:0] w);
    cyc();
    instr = w;
    instr_valid = 1'b1;
  endtask
  function automatic logic [8:0] rand_word();
    logic [3:0] f1;
    logic [2:0] f2;
    logic [1:0] f3;
    f1 = $urandom_range(0, 2) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
    f2 = $urandom_range(0, 2) == 0 ? 3'd0 : 3'($urandom_range(1, 7));
    f3 = $urandom_range(0, 2) == 0 ? 2'd0 : 2'($urandom_range(1, 3));
    return {f1, f2, f3};
  endfunction
  initial begin
    int dn;
    repeat (2) cyc();
    chk("rst_uop_valid", int'(uop_valid), 0);
    chk("rst_uop_data", int'(uop_data), 0);
    chk("rst_uop_phase", int'(uop_phase), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    #2 reset = 1'b1;
    cyc();
    chk("rel_instr_ready", int'(instr_ready), 1);
    // basic issue order
    uop_ready = 1'b1;
    push(9'b010110110);
    cyc(); instr_valid = 1'b0;
    chk("t1_level", int'(fifo_level), 1);
    cyc(); chk("t1_v0", int'(uop_valid), 1); chk("t1_p0", int'(uop_phase), 0); chk("t1_d0", int'(uop_data), 5);
    cyc(); chk("t1_p1", int'(uop_phase), 1); chk("t1_d1", int'(uop_data), 5);
    cyc(); chk("t1_p2", int'(uop_phase), 2); chk("t1_d2", int'(uop_data), 2);
    cyc(); chk("t1_done", int'(done), 1); chk("t1_idle", int'(uop_valid), 0);
    cyc(); chk("t1_done_off", int'(done), 0);
    // stall in phase 1
    push(9'b010110110);
    cyc(); instr_valid = 1'b0;
    cyc(); chk("t2_p0", int'(uop_phase), 0);
    cyc(); chk("t2_p1", int'(uop_phase), 1); uop_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(); chk("t2_hold_p", int'(uop_phase), 1); chk("t2_hold_d", int'(uop_data), 5); chk("t2_hold_v", int'(uop_valid), 1);
    end
    uop_ready = 1'b1;
    cyc(); chk("t2_p2", int'(uop_phase), 2); chk("t2_d2", int'(uop_data), 2);
    cyc(); chk("t2_done", int'(done), 1);
    // fill to capacity
    uop_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) chk("t3_full_ready", int'(instr_ready), 0);
      instr = i == 0 ? 9'h1ff : i == 1 ? 9'h0a5 : i == 2 ? 9'h123 : 9'h0ff;
      instr_valid = 1'b1;
    end
    cyc(); instr_valid = 1'b0;
    chk("t3_level", int'(fifo_level), 2);
    chk("t3_ready", int'(instr_ready), 0);
    uop_ready = 1'b1;
    dn = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (done) dn++;
    end
    chk("t3_dones", dn, 3);
    // back-to-back instructions, no bubble
    push(9'b010110110);
    push(9'b100111001);
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) instr_valid = 1'b0;
      if (i < 6) begin
        chk("t4_valid", int'(uop_valid), 1);
        chk("t4_phase", int'(uop_phase), i % 3);
      end
      if (i == 3) chk("t4_b_f1", int'(uop_data), 9);
      if (done) dn++;
    end
    chk("t4_dones", dn, 2);
    // reset mid-instruction
    push(9'b010110110);
    push(9'b100111001);
    cyc(); instr_valid = 1'b0;
    cyc(); chk("t5_p1", int'(uop_phase), 1);
    #2 reset = 1'b0;
    #1 chk("t5_rst_valid", int'(uop_valid), 0);
    chk("t5_rst_level", int'(fifo_level), 0);
    cyc();
    #2 reset = 1'b1;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done) dn++;
    end
    chk("t5_no_done", dn, 0);
    push(9'b010110110);
    cyc(); instr_valid = 1'b0;
    cyc(); chk("t5_restart_v", int'(uop_valid), 1); chk("t5_restart_p", int'(uop_phase), 0);
    repeat (4) cyc();
    // zero fields
    push(9'b000000010);
    cyc(); instr_valid = 1'b0;
    if (SKIP) begin
      cyc(); chk("t6_p", int'(uop_phase), 2); chk("t6_d", int'(uop_data), 2);
    end else begin
      cyc(); chk("t6_p0", int'(uop_phase), 0); chk("t6_d0", int'(uop_data), 0);
      cyc(); chk("t6_p1", int'(uop_phase), 1); chk("t6_d1", int'(uop_data), 0);
      cyc(); chk("t6_p2", int'(uop_phase), 2); chk("t6_d2", int'(uop_data), 2);
    end
    cyc(); chk("t6_done", int'(done), 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        cyc();
        #2 reset = 1'b1;
      end
      instr_valid = $urandom_range(0, 2) != 0;
      uop_ready = $urandom_range(0, 3) != 0;
      instr = rand_word();
    end
    instr_valid = 1'b0;
    uop_ready = 1'b1;
    repeat (12) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
